// File: rtl/morse_msg_ctrl_if.sv
// Character stream from the message controller to its consumer (UART TX or display).
interface morse_msg_ctrl_if;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;

  modport master (output out_data, output out_valid, input out_ready);
  modport slave  (input out_data, input out_valid, output out_ready);
endinterface

// File: rtl/morse_msg_ctrl.sv
// Morse message controller: buffers decoded letters, inserts word-gap spaces, streams to consumer.
// Optional MORSE_SEND_TERM_EN: send pulse pushes LF (8'h0A) and terminates the current word.
module morse_msg_ctrl #(
  parameter int unsigned DEPTH      = 16,
  parameter int unsigned GAP_CYCLES = 50_000_000,
  parameter int unsigned CNT_W      = 26
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [1:0]               sym_in,
  input  logic [7:0]               letter_in,
  input  logic                     letter_done,
  input  logic                     send,
  input  logic                     clear,
  morse_msg_ctrl_if.master         tx,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic                     overflow
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0]      FULL_CNT = DEPTH[AW:0];
  localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_CYCLES - 1);

  typedef enum logic {IDLE, IN_WORD} state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] gap_cnt, gap_cnt_nxt;
  logic [7:0]       mem [DEPTH];
  logic [AW-1:0]    rd_ptr, wr_ptr;
  logic             push, push_ok, pop, full, activity, letter_push;
  logic [7:0]       push_data;
`ifdef MORSE_SEND_TERM_EN
  logic             pend, pend_nxt;
`endif

  assign activity     = (sym_in != 2'b00) || letter_done;
  assign letter_push  = letter_done && (letter_in != 8'h00);
  assign tx.out_valid = (fifo_count != '0);
  assign tx.out_data  = tx.out_valid ? mem[rd_ptr] : '0;
  assign pop          = tx.out_valid && tx.out_ready;
  assign full         = (fifo_count == FULL_CNT);
  assign push_ok      = push && !clear && !(full && !pop);

  always_comb begin
    state_nxt   = state;
    gap_cnt_nxt = gap_cnt;
    push        = 1'b0;
    push_data   = '0;
`ifdef MORSE_SEND_TERM_EN
    pend_nxt    = pend;
`endif
    if (letter_push) begin
      push        = 1'b1;
      push_data   = letter_in;
      state_nxt   = IN_WORD;
      gap_cnt_nxt = '0;
    end else if (state == IN_WORD) begin
      if (activity) begin
        gap_cnt_nxt = '0;
      end else if (gap_cnt == GAP_LAST) begin
        push        = 1'b1;
        push_data   = 8'h20;
        state_nxt   = IDLE;
        gap_cnt_nxt = '0;
      end else begin
        gap_cnt_nxt = gap_cnt + CNT_W'(1);
      end
    end
`ifdef MORSE_SEND_TERM_EN
    // Terminator takes the push slot only when no letter/space claimed it; else it waits.
    if (send || pend) begin
      if (!push) begin
        push        = 1'b1;
        push_data   = 8'h0A;
        state_nxt   = IDLE;
        gap_cnt_nxt = '0;
        pend_nxt    = 1'b0;
      end else begin
        pend_nxt    = 1'b1;
      end
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      gap_cnt <= '0;
    end else if (clear) begin
      state   <= IDLE;
      gap_cnt <= '0;
    end else begin
      state   <= state_nxt;
      gap_cnt <= gap_cnt_nxt;
    end
  end

`ifdef MORSE_SEND_TERM_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     pend <= 1'b0;
    else if (clear) pend <= 1'b0;
    else            pend <= pend_nxt;
  end
`endif

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      fifo_count <= '0;
      overflow   <= 1'b0;
    end else if (clear) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      fifo_count <= '0;
      overflow   <= 1'b0;
    end else begin
      if (pop)     rd_ptr <= rd_ptr + AW'(1);
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (push && !push_ok) overflow <= 1'b1;
      unique case ({push_ok, pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase
    end
  end
endmodule

// File: tb/tb_morse_msg_ctrl.sv
// Randomized bench for morse_msg_ctrl against a queue-based reference model.
module tb_morse_msg_ctrl;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned GAP   = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] sym = '0;
  logic [7:0] letter = '0;
  logic       ld = 1'b0, snd = 1'b0, clr = 1'b0;
  logic [2:0] fifo_count;
  logic       overflow;

  morse_msg_ctrl_if oif ();

  morse_msg_ctrl #(.DEPTH(DEPTH), .GAP_CYCLES(GAP), .CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .sym_in(sym), .letter_in(letter),
    .letter_done(ld), .send(snd), .clear(clr), .tx(oif.master),
    .fifo_count(fifo_count), .overflow(overflow)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_bad = 0;

  // Reference: the buffered text as a queue, plus word/silence bookkeeping.
  byte unsigned q[$];
  bit           m_ovf = 0, in_word = 0, pend = 0;
  int unsigned  quiet = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete(); m_ovf = 0; in_word = 0; pend = 0; quiet = 0;
  endtask

  task automatic model_step();
    bit popv, pushv, fullv, lp, sp;
    byte unsigned c;
    popv = oif.out_ready && (q.size() != 0);
    if (clr) begin
      model_reset();
      return;
    end
    lp = ld && (letter != 8'h00);
    sp = 0;
    if (lp) begin
      in_word = 1; quiet = 0;
    end else if (in_word) begin
      if (sym != 2'b00 || ld) quiet = 0;
      else begin
        quiet++;
        if (quiet == GAP) begin sp = 1; in_word = 0; quiet = 0; end
      end
    end
    pushv = lp || sp;
    c = lp ? letter : 8'h20;
`ifdef MORSE_SEND_TERM_EN
    if (snd || pend) begin
      if (!pushv) begin
        pushv = 1; c = 8'h0A; pend = 0; in_word = 0; quiet = 0;
      end else pend = 1;
    end
`endif
    fullv = (q.size() == DEPTH) && !popv;
    if (popv) void'(q.pop_front());
    if (pushv) begin
      if (fullv) m_ovf = 1;
      else q.push_back(c);
    end
  endtask

  task automatic compare_all();
    check("valid", 32'(oif.out_valid), 32'(q.size() != 0));
    check("data",  32'(oif.out_data),  (q.size() != 0) ? 32'(q[0]) : 32'h0);
    check("count", 32'(fifo_count),    32'(q.size()));
    check("ovf",   32'(overflow),      32'(m_ovf));
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic drive(input logic [1:0] s, input logic [7:0] l, input logic d,
                       input logic sn, input logic c, input logic r);
    sym = s; letter = l; ld = d; snd = sn; clr = c; oif.out_ready = r;
  endtask

  task automatic idle(input int unsigned n, input logic r);
    drive(2'b00, 8'h00, 1'b0, 1'b0, 1'b0, r);
    for (int unsigned i = 0; i < n; i++) tick();
  endtask

  task automatic put(input logic [7:0] l, input logic r);
    drive(2'b00, l, 1'b1, 1'b0, 1'b0, r);
    tick();
  endtask

  task automatic do_clear();
    drive(2'b00, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
    tick();
  endtask

  initial begin
    oif.out_ready = 1'b0;
    #12;
    check("rst_valid", 32'(oif.out_valid), 32'h0);
    check("rst_data",  32'(oif.out_data),  32'h0);
    check("rst_count", 32'(fifo_count),    32'h0);
    check("rst_ovf",   32'(overflow),      32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();

    // Single letter in, single pop out.
    put(8'h41, 1'b0);
    check("a_data", 32'(oif.out_data), 32'h41);
    check("a_count", 32'(fifo_count), 32'h1);
    idle(1, 1'b1);
    check("a_empty", 32'(oif.out_valid), 32'h0);
    idle(GAP + 2, 1'b1);

    // Gap with restart by activity on the 5th quiet cycle, then full gap.
    do_clear();
    put(8'h45, 1'b0);
    idle(4, 1'b0);
    drive(2'b01, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0); tick();
    idle(GAP, 1'b0);
    check("gap_count", 32'(fifo_count), 32'h2);

    // Letter on the expiry cycle suppresses the space.
    do_clear();
    put(8'h45, 1'b0);
    idle(GAP - 1, 1'b0);
    put(8'h46, 1'b0);
    check("coinc_count", 32'(fifo_count), 32'h2);
    idle(GAP, 1'b0);

    // Overflow, push+pop while full, drain.
    do_clear();
    for (int unsigned i = 0; i < 5; i++) put(8'(8'h41 + i), 1'b0);
    check("ovf_set", 32'(overflow), 32'h1);
    put(8'h5A, 1'b1);
    check("full_pp", 32'(fifo_count), 32'h4);
    idle(6, 1'b1);

    // Clear with occupancy 3 and simultaneous push.
    do_clear();
    for (int unsigned i = 0; i < 3; i++) put(8'(8'h50 + i), 1'b0);
    drive(2'b00, 8'h58, 1'b1, 1'b0, 1'b1, 1'b1); tick();
    check("clr_count", 32'(fifo_count), 32'h0);

    // Send terminator (or plain space without the feature).
    put(8'h53, 1'b0);
    drive(2'b00, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0); tick();
    idle(GAP + 3, 1'b0);
    drive(2'b00, 8'h54, 1'b1, 1'b1, 1'b0, 1'b0); tick();
    idle(GAP + 3, 1'b1);

    // Randomized phases with varying activity density.
    for (int unsigned ph = 0; ph < 60; ph++) begin
      int unsigned dens, rdyp, len;
      dens = $urandom_range(0, 40);
      rdyp = $urandom_range(0, 100);
      len  = $urandom_range(20, 70);
      for (int unsigned i = 0; i < len; i++) begin
        ld     = ($urandom_range(0, 99) < dens);
        letter = ($urandom_range(0, 15) == 0) ? 8'h00 : 8'(8'h41 + $urandom_range(0, 25));
        sym    = ($urandom_range(0, 99) < dens) ? 2'($urandom_range(1, 3)) : 2'b00;
        oif.out_ready = ($urandom_range(0, 99) < rdyp);
        snd    = ($urandom_range(0, 59) == 0);
        clr    = ($urandom_range(0, 199) == 0);
        tick();
      end
      if (ph == 30) begin
        // Asynchronous reset in the middle of traffic.
        rst_n = 1'b0;
        #2;
        check("arst_valid", 32'(oif.out_valid), 32'h0);
        check("arst_count", 32'(fifo_count),    32'h0);
        check("arst_ovf",   32'(overflow),      32'h0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
      end
    end

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule

// File: doc/morse_msg_ctrl.md
Name: morse_msg_ctrl

Overview:
- Message controller downstream of the Morse letter FSM: captures each decoded letter (letter/done pair) into a FIFO and detects inter-word silence to insert ASCII space (8'h20).
- Schedules buffered characters to a ready/valid consumer (UART TX or display driver).
- Owns word-gap timing, FIFO occupancy, overflow reporting and clear sequencing for the decode path.

Parameters:
- DEPTH, 16, FIFO entries; power of two, >= 2
- GAP_CYCLES, 50_000_000, idle cycles after last letter before a space is inserted; >= 2
- CNT_W, 26, gap counter width; 2**CNT_W > GAP_CYCLES

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- sym_in  in  2  symbol classifier output; 2'b00 = no activity, any nonzero value = symbol activity
- letter_in  in  8  ASCII letter from letter FSM; sampled only when letter_done=1
- letter_done  in  1  one-cycle pulse, letter_in valid
- send  in  1  one-cycle message-terminate pulse (used only with optional feature)
- clear  in  1  synchronous flush: empties FIFO, clears overflow, returns FSM to IDLE
- out_data  out  8  character at FIFO head
- out_valid  out  1  FIFO non-empty
- out_ready  in  1  consumer accepts out_data when out_valid & out_ready
- fifo_count  out  $clog2(DEPTH)+1  current occupancy
- overflow  out  1  sticky; set when a push is dropped

Behaviour:
- Reset (rst_n=0, async): FIFO empty, pointers 0, fifo_count=0, out_valid=0, out_data=8'h00, overflow=0, gap counter=0, state=IDLE.
- FIFO: first-word-fall-through; out_data driven from mem[rd_ptr]; push at edge N gives out_valid=1 after edge N (visible in cycle N+1). Pop occurs on edge where out_valid & out_ready. Pointers wrap modulo DEPTH; count tracks separately, 0..DEPTH.
- Push sources, one per cycle, priority: letter > space > terminator.
- Letter push: letter_done=1 and letter_in != 8'h00. letter_in=8'h00 (invalid code) is dropped silently, no overflow, but still counts as activity.
- State machine:
  - IDLE: no word in progress; gap counter held at 0. letter_done with non-zero letter -> IN_WORD.
  - IN_WORD: gap counter increments each cycle with sym_in==0 and letter_done==0; any nonzero sym_in or letter_done resets it to 0. On counter == GAP_CYCLES-1 with no letter_done that cycle: push 8'h20, go IDLE, counter <= 0.
  - letter_done in same cycle as gap expiry: letter pushed, counter reset, no space, stay IN_WORD.
  - sym_in activity in IDLE does not change state.
- Full: push with count==DEPTH and no simultaneous pop -> data dropped, overflow<=1, pointers unchanged. Push and pop same cycle while full -> both succeed, count stays DEPTH.
- Empty: out_ready ignored when out_valid=0; pointers unchanged.
- clear: highest priority synchronous action; same-cycle push and pop discarded; next cycle fifo_count=0, out_valid=0, overflow=0, state=IDLE, counter=0.
- Async reset mid-transfer: immediate return to reset values; no partial pop.

Optional Feature:
- Macro MORSE_SEND_TERM_EN.
- Defined: send pulse pushes 8'h0A (LF). If state=IN_WORD, a space is not inserted; state -> IDLE, counter <= 0. Loses to letter_done or space push in same cycle: send is then held pending and pushed on the next free cycle. Subject to normal overflow rules.
- Undefined: send ignored. No pending register is synthesized.

Test Plan:
- Reset then letter_done with letter_in=8'h41 -> next cycle out_valid=1, out_data=8'h41, fifo_count=1; out_ready=1 for one cycle -> out_valid=0, count=0.
- GAP_CYCLES=8: push 'E', then sym_in=0 for 8 cycles -> 8'h20 pushed on 8th idle edge; FIFO holds 'E',' '. Activity at cycle 5 restarts the count.
- letter_done coincident with gap expiry -> only the letter pushed, no 8'h20, state remains IN_WORD.
- DEPTH=4, out_ready=0, push 5 letters 'A'..'E' -> count=4, overflow=1, drain yields A,B,C,D. Push plus pop while full -> count stays 4, overflow unchanged.
- clear asserted with count=3 and simultaneous push -> next cycle count=0, out_valid=0, overflow=0.
- With MORSE_SEND_TERM_EN: push 'S', send pulse -> FIFO 'S',8'h0A, no space follows. Without the macro: same stimulus -> 'S' then 8'h20 after GAP_CYCLES.
